// File: rtl/softmax_norm_64_if.sv
// Bundle of the softmax divide stage's data/handshake signals.
// The slave side is the normalizer; the master side feeds it.
interface softmax_norm_64_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned SW = 32
);
    logic                 i_en;
    logic                 i_valid;
    logic                 o_ready;
    logic [3:0]           i_length_mode;
    logic [64*DW-1:0]     i_in0_flat;
    logic signed [SW-1:0] i_sum64_0;
    logic signed [SW-1:0] i_sum32_0;
    logic signed [SW-1:0] i_sum32_1;
    logic signed [SW-1:0] i_sum16_0;
    logic signed [SW-1:0] i_sum16_1;
    logic signed [SW-1:0] i_sum16_2;
    logic signed [SW-1:0] i_sum16_3;
    logic                 o_valid;
    logic                 i_ready;
    logic [64*DW-1:0]     o_out_flat;
    logic [3:0]           o_length_mode;
    logic                 o_err;
    logic                 o_ovf;

    modport slave (
        input  i_en, i_valid, i_length_mode, i_in0_flat, i_sum64_0, i_sum32_0, i_sum32_1,
               i_sum16_0, i_sum16_1, i_sum16_2, i_sum16_3, i_ready,
        output o_ready, o_valid, o_out_flat, o_length_mode, o_err, o_ovf
    );

    modport master (
        output i_en, i_valid, i_length_mode, i_in0_flat, i_sum64_0, i_sum32_0, i_sum32_1,
               i_sum16_0, i_sum16_1, i_sum16_2, i_sum16_3, i_ready,
        input  o_ready, o_valid, o_out_flat, o_length_mode, o_err, o_ovf
    );
endinterface

// File: rtl/softmax_norm_64.sv
// Softmax divide stage: one restoring-division reciprocal per 16-lane group, then
// 16 lanes scaled per cycle by their group's reciprocal with saturation.
module softmax_norm_64 #(
    parameter int unsigned DW   = 16,
    parameter int unsigned SW   = 32,
    parameter int unsigned FRAC = 10,
    parameter int unsigned QW   = 21,
    parameter int unsigned LPC  = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    softmax_norm_64_if.slave  bus
);
    localparam int unsigned LANES  = 64;
    localparam int unsigned NG     = 4;
    localparam int unsigned NCHUNK = LANES / LPC;
    localparam int unsigned PW     = DW + QW + 1;
    localparam logic [4:0]  DivLast = 5'(QW - 1);
    localparam logic [4:0]  MulLast = 5'(NCHUNK - 1);
    localparam logic signed [PW-1:0] YMax = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] YMin = ~YMax;

    typedef enum logic [1:0] {StIdle, StDiv, StMul, StOut} state_e;

    state_e               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [LANES*DW-1:0]  lanes_q;
    logic [LANES*DW-1:0]  out_q;
    logic [3:0]           mode_q;
    logic                 err_q;
    logic                 ovf_q;
    logic [SW-1:0]        divisor_q [NG];
    logic [NG-1:0]        bad_q;
    logic [SW-1:0]        rem_q [NG];
    logic [QW-1:0]        quo_q [NG];

    logic                 mode_legal;
    logic [1:0]           mode_eff;
    logic signed [SW-1:0] sum16 [NG];
    logic signed [SW-1:0] sel_sum [NG];
    logic [NG-1:0]        sel_bad;
    logic                 cap_err;
    logic [SW:0]          div_shift [NG];
    logic [NG-1:0]        div_ge;
    logic [SW-1:0]        div_rem [NG];
    logic [5:0]           lane_idx [LPC];
    logic [DW-1:0]        lane_y [LPC];

    assign sum16[0] = bus.i_sum16_0;
    assign sum16[1] = bus.i_sum16_1;
    assign sum16[2] = bus.i_sum16_2;
    assign sum16[3] = bus.i_sum16_3;

    // Every 16-lane group gets its own divisor; wider groups just replicate the sum.
    always_comb begin
        mode_legal = bus.i_length_mode <= 4'd2;
        mode_eff   = mode_legal ? bus.i_length_mode[1:0] : 2'd0;
        for (int g = 0; g < NG; g++) begin
            case (mode_eff)
                2'd1:    sel_sum[g] = (g < 2) ? bus.i_sum32_0 : bus.i_sum32_1;
                2'd2:    sel_sum[g] = sum16[g];
                default: sel_sum[g] = bus.i_sum64_0;
            endcase
            sel_bad[g] = sel_sum[g][SW-1] | (sel_sum[g] == '0);
        end
        cap_err = ~mode_legal | (|sel_bad);
    end

    // Dividend 2^(2*FRAC) has only its MSB set, shifted in on the first iteration.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            div_shift[g] = {rem_q[g], cnt_q == '0};
            div_ge[g]    = div_shift[g] >= {1'b0, divisor_q[g]};
            div_rem[g]   = div_ge[g] ? SW'(div_shift[g] - {1'b0, divisor_q[g]})
                                     : div_shift[g][SW-1:0];
        end
    end

    for (genvar j = 0; j < LPC; j++) begin : g_lane
        logic [QW-1:0]        recip;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shifted;

        assign lane_idx[j] = 6'(cnt_q * LPC + j);
        assign recip       = bad_q[lane_idx[j][5:4]] ? '0 : quo_q[lane_idx[j][5:4]];
        assign prod        = $signed(lanes_q[32'(lane_idx[j]) * DW +: DW])
                             * $signed({1'b0, recip});
        assign shifted     = prod >>> FRAC;
        assign lane_y[j]   = (shifted > YMax) ? YMax[DW-1:0] :
                             (shifted < YMin) ? YMin[DW-1:0] : shifted[DW-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    state_d = StDiv;
                    cnt_d   = '0;
                end
            end
            StDiv: begin
                if (cnt_q == DivLast) begin
                    state_d = StMul;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StMul: begin
                if (cnt_q == MulLast) begin
                    state_d = StOut;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StOut: begin
                if (bus.i_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (bus.i_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lanes_q <= '0;
            out_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bad_q   <= '0;
            for (int g = 0; g < NG; g++) begin
                divisor_q[g] <= '0;
                rem_q[g]     <= '0;
                quo_q[g]     <= '0;
            end
        end else if (bus.i_en) begin
            ovf_q <= bus.i_valid & (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (bus.i_valid) begin
                        lanes_q <= bus.i_in0_flat;
                        mode_q  <= mode_legal ? bus.i_length_mode : 4'd0;
                        err_q   <= cap_err;
                        bad_q   <= sel_bad;
                        for (int g = 0; g < NG; g++) begin
                            divisor_q[g] <= sel_sum[g];
                            rem_q[g]     <= '0;
                            quo_q[g]     <= '0;
                        end
                    end
                end
                StDiv: begin
                    for (int g = 0; g < NG; g++) begin
                        rem_q[g] <= div_rem[g];
                        quo_q[g] <= {quo_q[g][QW-2:0], div_ge[g]};
                    end
                end
                StMul: begin
                    for (int j = 0; j < LPC; j++) begin
                        out_q[32'(lane_idx[j]) * DW +: DW] <= lane_y[j];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready       = state_q == StIdle;
    assign bus.o_valid       = state_q == StOut;
    assign bus.o_out_flat    = out_q;
    assign bus.o_length_mode = mode_q;
    assign bus.o_err         = err_q;
    assign bus.o_ovf         = ovf_q;
endmodule
